// File: rtl/z80_bus_bridge_pkg.sv
// z80_bus_bridge_pkg: shared FSM states, access-type encoding and timeout fill byte
package z80_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_MEM,
        ACC_IO,
        ACC_INTA
    } acc_t;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/z80_bus_decode.sv
// z80_bus_decode: classifies the current Z80 strobe pattern as memory, I/O or interrupt acknowledge
module z80_bus_decode
    import z80_bus_bridge_pkg::*;
(
    input  logic pin_nM1,
    input  logic pin_nMREQ,
    input  logic pin_nIORQ,
    input  logic pin_nRD,
    input  logic pin_nWR,
    input  logic pin_nRFSH,
    output acc_t kind,
    output logic active
);

    logic rw;
    logic mem;
    logic io;
    logic inta;

    assign rw   = !pin_nRD || !pin_nWR;
    assign mem  = !pin_nMREQ && pin_nRFSH && rw;
    assign io   = !pin_nIORQ && pin_nM1 && rw;
    assign inta = !pin_nIORQ && !pin_nM1;

    // Refresh is excluded inside mem, so it can never yield an access kind
    always_comb begin
        kind = mem  ? ACC_MEM  :
               io   ? ACC_IO   :
               inta ? ACC_INTA : ACC_NONE;
    end

    assign active = mem || io || inta;

endmodule

// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge: Z80 strobe-to-system-bus bridge; define Z80_BRIDGE_TIMEOUT_EN for the REQ timeout
module z80_bus_bridge
    import z80_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        pin_nM1,
    input  logic        pin_nMREQ,
    input  logic        pin_nIORQ,
    input  logic        pin_nRD,
    input  logic        pin_nWR,
    input  logic        pin_nRFSH,
    input  logic [15:0] pin_A,
    input  logic [7:0]  pin_D_in,
    output logic [7:0]  pin_D_out,
    output logic        pin_D_oe,
    output logic        pin_nWAIT,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    input  logic [7:0]  int_vector,
    output logic        timeout_flag
);

    state_t      state_q;
    logic        we_q;
    logic        io_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    acc_t        kind;
    logic        active;
    logic        start_bus;
    logic        ack_eff;
    logic [7:0]  ack_data;

    z80_bus_decode u_decode (
        .pin_nM1   (pin_nM1),
        .pin_nMREQ (pin_nMREQ),
        .pin_nIORQ (pin_nIORQ),
        .pin_nRD   (pin_nRD),
        .pin_nWR   (pin_nWR),
        .pin_nRFSH (pin_nRFSH),
        .kind      (kind),
        .active    (active)
    );

    assign start_bus = (kind == ACC_MEM) || (kind == ACC_IO);

`ifdef Z80_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        flag_q;
    logic        to_hit;

    assign to_hit       = (state_q == ST_REQ) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign ack_eff      = bus_ack || to_hit;
    assign ack_data     = bus_ack ? bus_rdata : TIMEOUT_FILL;
    assign timeout_flag = flag_q;

    // REQ is only entered from IDLE, so clearing in IDLE is clearing on REQ entry
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE)
                cnt_q <= '0;
            else if (state_q == ST_REQ)
                cnt_q <= cnt_q + 16'd1;
            if (to_hit && !bus_ack)
                flag_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg   = (TIMEOUT_CYCLES != 0);
    assign ack_eff      = bus_ack;
    assign ack_data     = bus_rdata;
    assign timeout_flag = 1'b0;
`endif

    // Access FSM: one bus transaction per strobe assertion, latched request fields, read capture
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_bus) begin
                        state_q <= ST_REQ;
                        addr_q  <= pin_A;
                        we_q    <= !pin_nWR;
                        io_q    <= (kind == ACC_IO);
                        wdata_q <= pin_D_in;
                    end else if (kind == ACC_INTA) begin
                        state_q <= ST_DONE;
                        rdata_q <= int_vector;
                    end
                end
                ST_REQ: begin
                    if (ack_eff) begin
                        if (active) begin
                            state_q <= ST_DONE;
                            if (!we_q)
                                rdata_q <= ack_data;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DONE: begin
                    if (!active)
                        state_q <= ST_IDLE;
                end
                ST_DRAIN: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = we_q;
    assign bus_io    = io_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign pin_D_out = rdata_q;
    assign pin_D_oe  = (state_q == ST_DONE) && (!pin_nRD || kind == ACC_INTA);
    // Interrupt acknowledge completes straight out of IDLE, so it never stretches the CPU cycle
    assign pin_nWAIT = !(active && ((state_q == ST_REQ) ||
                                    (state_q == ST_IDLE && kind != ACC_INTA)));

endmodule
